// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and flush controller for the r200 in-order core family. It sits beside
// decode and tracks every in-flight register write in a shift register with one
// entry per stage after ID (stage 1 = EX, stage NSTAGE = WB). From those entries
// and the instruction currently in ID it derives, with no added latency:
//   - operand forwarding selects (youngest producer wins),
//   - the load-use stall with its IF/ID hold and ID/EX bubble,
//   - the IF/ID flush for a redirect resolved in stage 1.
// Two saturating counters record stall cycles and effective redirects.
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 3,
  parameter int RAW        = 5,
  parameter int LOAD_STAGE = 3,
  parameter int CNTW       = 16,
  parameter int SELW       = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RAW-1:0]    id_rs1,
  input  logic [RAW-1:0]    id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [RAW-1:0]    id_rd,
  input  logic              id_regwr,
  input  logic              id_isload,
  input  logic              ex_redirect,
  output logic [SELW-1:0]   fwd1_sel,
  output logic [SELW-1:0]   fwd2_sel,
  output logic              stall,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [NSTAGE-1:0] stg_valid,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   flush_cnt
);

  // Stage entries; index k-1 holds stage k. Bubbles carry v=0 and cleared fields.
  logic [NSTAGE-1:0]          v_q;
  logic [NSTAGE-1:0]          regwr_q;
  logic [NSTAGE-1:0]          isload_q;
  logic [NSTAGE-1:0][RAW-1:0] rd_q;

  // Per-stage source matches and the resulting youngest-producer decisions.
  logic [NSTAGE-1:0] match1;
  logic [NSTAGE-1:0] match2;
  logic [SELW-1:0]   sel1;
  logic [SELW-1:0]   sel2;
  logic              haz1;
  logic              haz2;
  logic              redir;
  logic              issue;

  // Compare both ID sources against every tracked writer; x0 and unused sources never match.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      match1[k] = id_rs1_used && (id_rs1 != '0) && v_q[k] && regwr_q[k] && (rd_q[k] == id_rs1);
      match2[k] = id_rs2_used && (id_rs2 != '0) && v_q[k] && regwr_q[k] && (rd_q[k] == id_rs2);
    end
  end

  // Pick the youngest match by scanning oldest to youngest so the last hit wins;
  // a load that has not yet reached LOAD_STAGE cannot supply its data.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (match1[k-1]) begin
        sel1 = SELW'(k);
        haz1 = isload_q[k-1] && (k < LOAD_STAGE);
      end
      if (match2[k-1]) begin
        sel2 = SELW'(k);
        haz2 = isload_q[k-1] && (k < LOAD_STAGE);
      end
    end
  end

  // Control decisions; a redirect only counts when stage 1 really holds the branch, and it overrides a stall.
  always_comb begin
    redir        = ex_redirect && v_q[0];
    stall        = id_valid && (haz1 || haz2) && !redir;
    issue        = id_valid && !stall && !redir;
    if_id_hold   = stall;
    if_id_flush  = redir;
    id_ex_bubble = !issue;
    fwd1_sel     = sel1;
    fwd2_sel     = sel2;
    stg_valid    = v_q;
  end

  // Advance the stage entries every clock; stage 1 takes the issued instruction or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q      <= '0;
      regwr_q  <= '0;
      isload_q <= '0;
      rd_q     <= '0;
    end else begin
      v_q[0]      <= issue;
      regwr_q[0]  <= issue && id_regwr;
      isload_q[0] <= issue && id_isload;
      rd_q[0]     <= issue ? id_rd : '0;
      for (int k = 1; k < NSTAGE; k++) begin
        v_q[k]      <= v_q[k-1];
        regwr_q[k]  <= regwr_q[k-1];
        isload_q[k] <= isload_q[k-1];
        rd_q[k]     <= rd_q[k-1];
      end
    end
  end

  // Saturating performance counters: one count per stalled cycle, one per effective redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redir && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard and flush controller for the r200 in-order core family.
- Replaces the hardwired three-stage forwarding/stall logic. Tracks in-flight register writes in an internal per-stage shift register, so depth is not fixed.
- Per cycle, produces forwarding selects, load-use stall, IF/ID hold, IF/ID flush and ID/EX bubble.
- Counts stall cycles and flushes.
- Sits beside the decode stage. Its outputs drive the IF/ID and ID/EX pipeline registers and the operand muxes.

Parameters:
- NSTAGE, 3: number of tracked stages after decode. Stage 1 is EX; stage NSTAGE is WB.
- RAW, 5: register address width.
- LOAD_STAGE, 3: first stage from which load data is forwardable. Range 1..NSTAGE.
- CNTW, 16: width of the performance counters.
- SELW, $clog2(NSTAGE+1): width of the forwarding selects.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  RAW  source 1 address
- id_rs2  in  RAW  source 2 address
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  RAW  destination address
- id_regwr  in  1  instruction writes rd
- id_isload  in  1  instruction is a load
- ex_redirect  in  1  instruction in stage 1 resolved as taken branch or jump
- fwd1_sel  out  SELW  0 = register file, k = forward from stage k
- fwd2_sel  out  SELW  same encoding, for rs2
- stall  out  1  load-use stall
- if_id_hold  out  1  IF/ID register keeps its value
- if_id_flush  out  1  IF/ID register loads a bubble
- id_ex_bubble  out  1  ID/EX register loads a bubble
- stg_valid  out  NSTAGE  bit k-1 = stage k holds a valid instruction
- stall_cnt  out  CNTW  count of stall cycles
- flush_cnt  out  CNTW  count of effective redirects

Behaviour:
Stage entries
- Entry k holds {v, rd, regwr, isload} for k = 1..NSTAGE.
- Every clock, entry k+1 takes entry k. The entry shifted out of NSTAGE is discarded; the register file writes it at that edge.
- Entry 1 takes {1, id_rd, id_regwr, id_isload} when issue=1, otherwise a bubble (v=0).

Redirect
- redir = ex_redirect & v[1]. ex_redirect with stage 1 empty is ignored.

Match and forwarding
- Match k for rsX: rsX_used & rsX!=0 & v[k] & regwr[k] & rd[k]==rsX.
- fwdX_sel = the smallest matching k (youngest wins), or 0 if nothing matches.

Hazard and control outputs
- Per-source hazard: the youngest match is a load with k < LOAD_STAGE.
- stall = id_valid & (haz1 | haz2) & ~redir. Redirect has priority over stall.
- issue = id_valid & ~stall & ~redir.
- if_id_hold = stall.
- if_id_flush = redir.
- id_ex_bubble = ~issue.
- All of the above are combinational from the current entries and ID inputs, with zero latency.
- A non-load result is forwardable from stage 1 onward.

Counters
- stall_cnt += 1 on every clock with stall=1.
- flush_cnt += 1 on every clock with redir=1.
- Both saturate at 2^CNTW-1.

Reset
- rst asserted clears all v, all entries and both counters immediately, independent of clk, including mid-stream.
- With entries cleared: fwd*_sel=0, stall=0, if_id_hold=0, if_id_flush=0, stg_valid=0, counters=0, id_ex_bubble=~id_valid.
- The first clock edge after rst deasserts behaves normally.

Boundary cases
- rd=0 never matches.
- Unused sources never match and never stall.
- Both sources hazarding stalls once per cycle; the counter increments by 1, not 2.
- With LOAD_STAGE=1 no stall is ever generated.

Test Plan:
- Back-to-back ALU dependence. Issue rd=5 regwr=1 isload=0; next cycle ID has rs1=5 used -> fwd1_sel=1, stall=0, id_ex_bubble=0. Cycle after that with rs1=5 -> fwd1_sel=2.
- Load-use, defaults. Issue load rd=6; next ID has rs2=6 used -> stall=1 and if_id_hold=1 for exactly 2 cycles (load in stages 1 and 2), then fwd2_sel=3, stall=0; stall_cnt=2; stg_valid shows the inserted bubbles.
- Youngest wins and x0. rd=7 in stage 3 and rd=7 in stage 1, ID rs1=7 -> fwd1_sel=1. A writer with rd=0 and ID rs1=0 -> fwd1_sel=0.
- Redirect beats load-use. Hazard present and ex_redirect=1 with v[1]=1 -> stall=0, if_id_flush=1, id_ex_bubble=1; next cycle stg_valid[0]=0, flush_cnt=1. With ex_redirect=1 and v[1]=0 -> no flush, flush_cnt unchanged.
- Parametrised depth, NSTAGE=5, LOAD_STAGE=4. Load rd=9 followed by a user of rs1=9 -> 3 stall cycles, then fwd1_sel=4. SELW=3.
- Async reset and saturation.
  - Assert rst between clock edges with 3 valid entries -> stg_valid=0 and counters=0 before the next edge.
  - With CNTW=4, hold a hazard for 20 cycles -> stall_cnt reaches 15 and stays at 15.
